// File: rtl/gpio_port.sv
// Memory-mapped GPIO: registered LED outputs, synchronised and debounced switch inputs.
// Define GPIO_IRQ_EN to build the change-detect interrupt (IRQ_STATUS, IRQ_ENABLE, IRQ).
module gpio_port #(
    parameter int OUT_WIDTH = 8,
    parameter int IN_WIDTH  = 4,
    parameter int DB_BITS   = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [1:0]           ADDR,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [15:0]          DOUT,
    output logic [15:0]          DIN,
    input  logic [IN_WIDTH-1:0]  PIN_IN,
    output logic [OUT_WIDTH-1:0] PIN_OUT,
    output logic                 IRQ
);

    // Bus protocol: RD and WR are single-cycle strobes with ADDR stable while high.
    // A write takes effect at the strobed edge; read data lands in DIN at the strobed
    // edge and is held until the next read. RD with WR returns the pre-write value.

    localparam logic [DB_BITS-1:0] CNT_ONE = 1;

    logic [IN_WIDTH-1:0] s1, s2, db, db_nxt;
    logic [DB_BITS-1:0]  cnt     [IN_WIDTH];
    logic [DB_BITS-1:0]  cnt_nxt [IN_WIDTH];
    logic [15:0]         rd_data;
    logic                unused_dout;

    assign unused_dout = ^DOUT;

    // A bit's counter only advances while s2 disagrees with db; any agreement restarts it.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < IN_WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == db[i]) begin
                cnt_nxt[i] = '0;
            end else if (&cnt[i]) begin
                db_nxt[i]  = s2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1 <= PIN_IN;
            s2 <= s1;
            db <= db_nxt;
            for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

`ifdef GPIO_IRQ_EN
    logic [IN_WIDTH-1:0] irq_status, irq_enable, w1c;
    logic                irq_q;

    assign w1c = (WR && ADDR == 2'd2) ? DOUT[IN_WIDTH-1:0] : '0;
    assign IRQ = irq_q;

    // A new db edge overrides a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            irq_status <= '0;
            irq_enable <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~w1c) | (db_nxt ^ db);
            if (WR && ADDR == 2'd3) irq_enable <= DOUT[IN_WIDTH-1:0];
            irq_q <= |(irq_status & irq_enable);
        end
    end
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (ADDR)
            2'd0: rd_data[IN_WIDTH-1:0]  = db;
            2'd1: rd_data[OUT_WIDTH-1:0] = PIN_OUT;
`ifdef GPIO_IRQ_EN
            2'd2: rd_data[IN_WIDTH-1:0]  = irq_status;
            2'd3: rd_data[IN_WIDTH-1:0]  = irq_enable;
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            PIN_OUT <= '0;
            DIN     <= '0;
        end else begin
            if (WR && ADDR == 2'd1) PIN_OUT <= DOUT[OUT_WIDTH-1:0];
            if (RD) DIN <= rd_data;
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: reads push expected DIN into a queue that a monitor
// pops one cycle after each RD strobe; pin and IRQ levels are checked in line.
module tb_gpio_port;

    localparam int OW = 8;
    localparam int IW = 4;
    localparam int DB = 4;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [1:0]    ADDR = '0;
    logic          RD = 1'b0;
    logic          WR = 1'b0;
    logic [15:0]   DOUT = '0;
    logic [15:0]   DIN;
    logic [IW-1:0] PIN_IN = '0;
    logic [OW-1:0] PIN_OUT;
    logic          IRQ;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    gpio_port #(.OUT_WIDTH(OW), .IN_WIDTH(IW), .DB_BITS(DB)) dut (
        .CLK(CLK), .RESETN(RESETN), .ADDR(ADDR), .RD(RD), .WR(WR), .DOUT(DOUT),
        .DIN(DIN), .PIN_IN(PIN_IN), .PIN_OUT(PIN_OUT), .IRQ(IRQ)
    );

    // clock / reset
    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        WR = 1'b1;
        tick();
        WR = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        ADDR = a;
        RD = 1'b1;
        tick();
        RD = 1'b0;
    endtask

    // scoreboard monitor: DIN is presented one cycle after each sampled RD
    initial forever begin
        @(posedge CLK);
        if (RD === 1'b1) begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL din_unexpected: got %h with empty queue", DIN);
            end else begin
                check("din_read", DIN, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        // reset state
        #2;
        check("reset_pin_out", 16'(PIN_OUT), 16'h0000);
        check("reset_din", DIN, 16'h0000);
        check("reset_irq", 16'(IRQ), 16'h0000);
        tick(2);
        RESETN = 1'b1;
        tick(20);

        // register access
        bus_read(2'd0, 16'h0000);
        bus_write(2'd1, 16'hA5C3);
        check("pin_out_write", 16'(PIN_OUT), 16'h00C3);
        bus_read(2'd1, 16'h00C3);
        bus_write(2'd0, 16'hFFFF);
        bus_read(2'd0, 16'h0000);

        // simultaneous read and write returns the old value
        exp_q.push_back(16'h00C3);
        ADDR = 2'd1;
        DOUT = 16'h005A;
        RD = 1'b1;
        WR = 1'b1;
        tick();
        RD = 1'b0;
        WR = 1'b0;
        check("pin_out_rdwr", 16'(PIN_OUT), 16'h005A);
        bus_read(2'd1, 16'h005A);

        // debounce: db still 0 after edge N+16, 9 after edge N+17
        PIN_IN = 4'h9;
        tick(17);
        bus_read(2'd0, 16'h0000);
        tick(30);
        bus_read(2'd0, 16'h0009);
        PIN_IN = 4'h0;
        tick(30);
        bus_read(2'd0, 16'h0000);
        PIN_IN = 4'h9;
        tick(18);
        bus_read(2'd0, 16'h0009);
        tick(30);
        PIN_IN = 4'h0;
        tick(30);
        bus_read(2'd0, 16'h0000);

`ifdef GPIO_IRQ_EN
        bus_read(2'd2, 16'h0009);
        bus_write(2'd2, 16'h000F);
        bus_read(2'd2, 16'h0000);
`endif

        // glitch of 10 cycles on bit 2 is rejected
        PIN_IN = 4'h4;
        tick(10);
        PIN_IN = 4'h0;
        tick(30);
        bus_read(2'd0, 16'h0000);
        check("irq_after_glitch", 16'(IRQ), 16'h0000);
`ifdef GPIO_IRQ_EN
        bus_read(2'd2, 16'h0000);

        // interrupt flow
        bus_write(2'd3, 16'h0001);
        PIN_IN = 4'h1;
        tick(18);
        check("irq_at_db_edge", 16'(IRQ), 16'h0000);
        tick();
        check("irq_set", 16'(IRQ), 16'h0001);
        bus_read(2'd2, 16'h0001);
        bus_read(2'd0, 16'h0001);
        bus_write(2'd2, 16'h0001);
        check("irq_at_w1c_edge", 16'(IRQ), 16'h0001);
        tick();
        check("irq_cleared", 16'(IRQ), 16'h0000);
        bus_read(2'd2, 16'h0000);

        // W1C on the edge where db falls: set wins
        PIN_IN = 4'h0;
        tick(17);
        bus_write(2'd2, 16'h0001);
        bus_read(2'd2, 16'h0001);
        bus_read(2'd0, 16'h0000);
        check("irq_set_wins", 16'(IRQ), 16'h0001);

        // enable written while status already pending
        bus_write(2'd3, 16'h0000);
        tick();
        check("irq_disabled", 16'(IRQ), 16'h0000);
        bus_write(2'd3, 16'h0001);
        check("irq_enable_edge", 16'(IRQ), 16'h0000);
        tick();
        check("irq_enable_late", 16'(IRQ), 16'h0001);
        bus_read(2'd3, 16'h0001);
        bus_write(2'd3, 16'hFFFF);
        bus_read(2'd3, 16'h000F);
`else
        bus_write(2'd3, 16'hFFFF);
        bus_write(2'd2, 16'hFFFF);
        bus_read(2'd2, 16'h0000);
        bus_read(2'd3, 16'h0000);
        PIN_IN = 4'hF;
        tick(20);
        check("irq_off_rise", 16'(IRQ), 16'h0000);
        bus_read(2'd0, 16'h000F);
        PIN_IN = 4'h0;
        tick(20);
        check("irq_off_fall", 16'(IRQ), 16'h0000);
        bus_read(2'd2, 16'h0000);
`endif

        // reset eight cycles into a debounce
        bus_write(2'd1, 16'h00A5);
        bus_read(2'd1, 16'h00A5);
        PIN_IN = 4'h6;
        tick(8);
        #2;
        RESETN = 1'b0;
        #1;
        check("async_rst_pin_out", 16'(PIN_OUT), 16'h0000);
        check("async_rst_din", DIN, 16'h0000);
        check("async_rst_irq", 16'(IRQ), 16'h0000);
        tick(3);
        RESETN = 1'b1;
        tick(17);
        bus_read(2'd0, 16'h0000);
        tick();
        bus_read(2'd0, 16'h0006);
`ifdef GPIO_IRQ_EN
        bus_read(2'd2, 16'h0006);
        bus_read(2'd3, 16'h0000);
`endif
        tick(2);
        check("irq_after_reset", 16'(IRQ), 16'h0000);

        tick(3);
        check("queue_drain", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO peripheral for the dev board. It drives up to 16 output pins (LEDs) and samples up to 16 input pins (DIP switches, buttons) through a two-flop synchroniser and a per-bit debounce counter. Optional change-detect interrupt logic is included. It sits on the CPU's I/O bus behind the address decoder and replaces the fixed 8-LED / 4-switch GPIO logic in the board wrapper.

## Interface
- `OUT_WIDTH`, 8: number of output pins, 1..16.
- `IN_WIDTH`, 4: number of input pins, 1..16.
- `DB_BITS`, 4: debounce counter width. An input must be stable for 2^DB_BITS cycles to be accepted. Range 1..20.

- `CLK` in 1: system clock; all logic on rising edge.
- `RESETN` in 1: reset, asynchronous assert, active-low.
- `ADDR` in 2: register select, decoded as word index.
- `RD` in 1: read strobe, one cycle per access.
- `WR` in 1: write strobe, one cycle per access.
- `DOUT` in 16: CPU write data.
- `DIN` out 16: read data to CPU, registered.
- `PIN_IN` in IN_WIDTH: asynchronous board inputs.
- `PIN_OUT` out OUT_WIDTH: board outputs, registered.
- `IRQ` out 1: level interrupt request, registered.

## Operation
- Register map, unused upper bits read 0:
  - 0 DATA_IN: RO debounced inputs. Writes are ignored.
  - 1 DATA_OUT: RW. Writes take `DOUT[OUT_WIDTH-1:0]`; reads return the current `PIN_OUT`.
  - 2 IRQ_STATUS: RO, write-1-to-clear per bit.
  - 3 IRQ_ENABLE: RW, IN_WIDTH bits.
- Input path, per bit:
  - Stage s1 <= `PIN_IN`; stage s2 <= s1.
  - Debounced value db and counter cnt[DB_BITS-1:0] are held per bit.
  - If s2 == db: cnt <= 0.
  - Else if cnt == 2^DB_BITS-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than 2^DB_BITS cycles never reaches db.
- Change detect: a bit of IRQ_STATUS is set on any cycle where db changes (both edges), regardless of enable.
- `IRQ` <= |(IRQ_STATUS & IRQ_ENABLE).
- Reads: on a rising edge with `RD`=1, `DIN` <= the selected register, zero-extended. `DIN` holds its value otherwise.
- `RD` and `WR` in the same cycle: both are performed, and `DIN` captures the pre-write value.
- Reset (`RESETN`=0, any time, including mid-debounce): s1, s2, db, cnt, `PIN_OUT`, `DIN`, IRQ_STATUS, IRQ_ENABLE and `IRQ` all go to 0 immediately. Any debounce in progress is discarded.
- Inputs held high through reset are accepted after the debounce interval and set their STATUS bits. ENABLE is 0 after reset, so `IRQ` stays 0.

## Timing
- Write latency: `PIN_OUT` changes at the edge that samples `WR`=1.
- Read latency: `DIN` is valid one cycle after `RD`.
- Input latency: a clean `PIN_IN` change first sampled at edge N appears in db at edge N+1+2^DB_BITS. That is 17 cycles for DB_BITS=4.
- Status latency: the STATUS bit sets at the same edge as the db change. `IRQ` asserts one edge later when enabled.
- W1C and a new set event on the same bit in the same cycle: the set wins and the bit stays 1.
- Enable written to 1 while STATUS is already 1: `IRQ` asserts one edge after the write.
- `ADDR` must be stable whenever `RD` or `WR` is high. `RD` and `WR` must not be held high across consecutive transfers; each strobe is one cycle.

## Configuration
- `GPIO_IRQ_EN` defined: the change-detect logic, IRQ_STATUS, IRQ_ENABLE and `IRQ` are built as described above.
- `GPIO_IRQ_EN` undefined:
  - Registers 2 and 3 read 0 and ignore writes.
  - `IRQ` is tied to 0.
  - No status or enable flops are synthesised.
  - The debounce path is unchanged.

## Test plan
- Reset and write:
  - Stimulus: apply reset, then WR addr1 with `DOUT`=16'hA5C3 (OUT_WIDTH=8).
  - Required: `PIN_OUT`=8'hC3 at the write edge. RD addr1 gives `DIN`=16'h00C3 next cycle. RD addr0 after reset with `PIN_IN`=0 gives 0.
- Debounce accept:
  - Stimulus: `PIN_IN` goes 4'h0 to 4'h9 and is held (DB_BITS=4).
  - Required: db is still 0 at edge N+16 and equals 4'h9 at edge N+17. RD addr0 gives 16'h0009.
- Glitch reject:
  - Stimulus: pulse `PIN_IN[2]` high for 10 cycles, then low.
  - Required: db[2] stays 0 and STATUS[2] stays 0 throughout.
- Interrupt flow (`GPIO_IRQ_EN`):
  - Stimulus: set ENABLE=4'h1, then toggle `PIN_IN[0]` and hold it.
  - Required: STATUS=4'h1 and `IRQ`=1 one edge later. W1C with 16'h0001 clears STATUS and drops `IRQ` the following edge. A W1C coinciding with a db change leaves the bit set.
- Reset mid-debounce:
  - Stimulus: assert `RESETN`=0 eight cycles into a stable `PIN_IN` change.
  - Required: all outputs are 0 asynchronously. After release, db accepts the value only after a full 1+2^DB_BITS cycles.
- Macro off:
  - Stimulus: build without `GPIO_IRQ_EN`, write 16'hFFFF to addr3, toggle inputs.
  - Required: RD addr2 and addr3 return 0, and `IRQ` stays 0.
